// File: rtl/instr_fetch_ctrl.sv
// Purpose: fetch sequencer; owns the PC, addresses instr_memory, registers word+PC for decode.
// Latency: 1 cycle from read_address to if_valid; 1 instruction/cycle while if_ready is high.
// Backpressure: if_valid && !if_ready stalls the PC and holds the output stage unchanged.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] read_address,
    input  logic [31:0] instruction,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_HALT,
        S_FAULT
    } state_t;

    // First byte address past the end of instr_memory (33 bits so the compare cannot wrap).
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;

    logic accept;
    logic stage_free;
    logic pc_in_range;
    logic redirect_bad;

    assign accept       = if_valid_q && if_ready;
    assign stage_free   = !if_valid_q || if_ready;
    assign pc_in_range  = ({1'b0, pc_q} < PC_LIMIT);
    assign redirect_bad = (redirect_pc[1:0] != 2'b00);

    // Next-state logic: FSM transitions, PC sequencing, output-stage capture and accept counting.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fetch_count_d = fetch_count_q;

        // A handshake always completes and counts, even in a redirect cycle.
        if (accept) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                pc_d = RESET_PC;
                if (start) begin
                    state_d       = S_RUN;
                    fetch_count_d = 32'd0;
                end
            end

            S_RUN, S_DRAIN: begin
                if (redirect) begin
                    // Flush the output stage; a misaligned target is fatal and leaves the PC alone.
                    if_valid_d = 1'b0;
                    if (redirect_bad) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = S_RUN;
                    end
                end else if (state_q == S_DRAIN) begin
                    // Wait for decode to take the halt word, then park.
                    if (accept) begin
                        if_valid_d = 1'b0;
                        state_d    = S_HALT;
                    end
                end else if (stage_free) begin
                    if (!pc_in_range) begin
                        if_valid_d = 1'b0;
                        state_d    = S_FAULT;
                    end else begin
                        if_instr_d = instruction;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        // The PC steps past the halt word once and then stays put in DRAIN.
                        pc_d       = pc_q + 32'd4;
                        if (instruction == HALT_WORD) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end

            S_HALT: begin
                if (start) begin
                    state_d       = S_RUN;
                    pc_d          = RESET_PC;
                    fetch_count_d = 32'd0;
                end
            end

            S_FAULT: begin
                if_valid_d = 1'b0;
            end

            default: begin
                state_d    = S_FAULT;
                if_valid_d = 1'b0;
            end
        endcase

        halted_d = (state_d == S_HALT);
        fault_d  = (state_d == S_FAULT);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'd0;
            if_pc_q       <= 32'd0;
            fetch_count_q <= 32'd0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fetch_count_q <= fetch_count_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
        end
    end

    assign read_address = pc_q;
    assign if_valid     = if_valid_q;
    assign if_instr     = if_instr_q;
    assign if_pc        = if_pc_q;
    assign fetch_count  = fetch_count_q;
    assign halted       = halted_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed stimulus, per-cycle reference model, literal spot checks.
module tb_instr_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] MEM_BYTES = 32'd256;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_HALT  = 3;
    localparam int M_FAULT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start;
    logic [31:0] read_address;
    logic [31:0] instruction;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    int vectors    = 0;
    int miscompares = 0;
    bit cmp_en     = 1'b0;

    logic [31:0] imem [64];
    logic [31:0] line [6];

    instr_fetch_ctrl #(
        .RESET_PC  (RESET_PC),
        .IMEM_WORDS(64),
        .HALT_WORD (HALT_WORD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .read_address(read_address),
        .instruction (instruction),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory; out-of-range addresses read as zero.
    assign instruction = (read_address < MEM_BYTES) ? imem[read_address[7:2]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The output stage is a queue of at most one {pc, word}; a word leaves when decode takes it,
    // and a new word enters whenever the queue is empty after that (in run mode).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    ent_t        stage[$];
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_count;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = 32'h0;
        if (a < MEM_BYTES) w = imem[a[7:2]];
        return w;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode  = M_IDLE;
                m_pc    = RESET_PC;
                m_count = 32'd0;
                stage.delete();
            end else begin
                bit took;
                took = (stage.size() != 0) && if_ready;
                if (took) begin
                    stage.delete();
                    m_count = m_count + 32'd1;
                end
                if (m_mode == M_IDLE || m_mode == M_HALT) begin
                    if (start) begin
                        m_mode  = M_RUN;
                        m_pc    = RESET_PC;
                        m_count = 32'd0;
                    end
                end else if (m_mode == M_RUN || m_mode == M_DRAIN) begin
                    if (redirect) begin
                        stage.delete();
                        if (redirect_pc % 4 != 0) begin
                            m_mode = M_FAULT;
                        end else begin
                            m_pc   = redirect_pc;
                            m_mode = M_RUN;
                        end
                    end else if (m_mode == M_DRAIN) begin
                        if (took) m_mode = M_HALT;
                    end else if (stage.size() == 0) begin
                        if (m_pc >= MEM_BYTES) begin
                            m_mode = M_FAULT;
                        end else begin
                            ent_t e;
                            e.pc   = m_pc;
                            e.word = mem_word(m_pc);
                            stage.push_back(e);
                            m_pc = m_pc + 32'd4;
                            if (e.word == HALT_WORD) m_mode = M_DRAIN;
                        end
                    end
                end
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("m_read_address", read_address, m_pc);
                chk("m_if_valid", 32'(if_valid), 32'(stage.size() != 0));
                if (stage.size() != 0) begin
                    chk("m_if_instr", if_instr, stage[0].word);
                    chk("m_if_pc", if_pc, stage[0].pc);
                end
                chk("m_halted", 32'(halted), 32'(m_mode == M_HALT));
                chk("m_fault", 32'(fault), 32'(m_mode == M_FAULT));
                chk("m_fetch_count", fetch_count, m_count);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        line[0] = 32'h8C080005;
        line[1] = 32'h02324820;
        line[2] = 32'h02325022;
        line[3] = 32'hAC09000A;
        line[4] = 32'h02295820;
        line[5] = 32'h110B0004;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        for (int i = 0; i < 6; i++) imem[i] = line[i];
        imem[6] = HALT_WORD;

        start = 1'b0; if_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        #10;
        chk("rst_read_address", read_address, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_fetch_count", fetch_count, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_if_valid", 32'(if_valid), 32'h0);

        // Straight-line fetch
        start = 1'b1; if_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("start_read_address", read_address, 32'h0);
        chk("start_if_valid", 32'(if_valid), 32'h0);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("line_if_valid", 32'(if_valid), 32'h1);
            chk("line_if_instr", if_instr, line[i]);
            chk("line_if_pc", if_pc, 32'(4 * i));
            tick();
        end
        chk("line_fetch_count", fetch_count, 32'd6);

        // Halt word at 24
        chk("halt_if_pc", if_pc, 32'd24);
        chk("halt_if_instr", if_instr, 32'hFFFFFFFF);
        chk("halt_read_address", read_address, 32'd28);
        tick();
        chk("halted_set", 32'(halted), 32'h1);
        chk("halted_if_valid", 32'(if_valid), 32'h0);
        chk("halted_read_address", read_address, 32'd28);
        chk("halted_fetch_count", fetch_count, 32'd7);
        tick();
        chk("halted_hold_addr", read_address, 32'd28);

        // Restart from HALT
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_count", fetch_count, 32'd0);
        chk("restart_read_address", read_address, 32'd0);
        chk("restart_halted", 32'(halted), 32'h0);
        tick();
        chk("restart_if_instr", if_instr, 32'h8C080005);
        chk("restart_if_pc", if_pc, 32'd0);
        tick();
        tick();

        // Backpressure at if_pc=8
        if_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_if_instr", if_instr, 32'h02325022);
            chk("bp_if_pc", if_pc, 32'd8);
            chk("bp_read_address", read_address, 32'd12);
        end
        if_ready = 1'b1;
        tick();
        chk("bp_next_instr", if_instr, 32'hAC09000A);
        chk("bp_fetch_count", fetch_count, 32'd3);
        tick();
        chk("pre_redir_if_pc", if_pc, 32'd16);

        // Redirect to 4 while if_pc=16 is held
        if_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'd4;
        tick();
        redirect = 1'b0; if_ready = 1'b1;
        chk("redir_if_valid", 32'(if_valid), 32'h0);
        chk("redir_read_address", read_address, 32'd4);
        chk("redir_fetch_count", fetch_count, 32'd4);
        tick();
        chk("redir_if_instr", if_instr, 32'h02324820);
        chk("redir_if_pc", if_pc, 32'd4);
        chk("redir_count_hold", fetch_count, 32'd4);

        // Misaligned redirect with a simultaneous accept
        redirect = 1'b1; redirect_pc = 32'h6;
        tick();
        redirect = 1'b0; start = 1'b1;
        chk("misal_fault", 32'(fault), 32'h1);
        chk("misal_if_valid", 32'(if_valid), 32'h0);
        chk("misal_fetch_count", fetch_count, 32'd5);
        chk("misal_pc_hold", read_address, 32'd8);
        tick();
        start = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
        repeat (2) begin
            tick();
            chk("fault_sticky", 32'(fault), 32'h1);
            chk("fault_if_valid", 32'(if_valid), 32'h0);
        end
        redirect = 1'b0;

        // Out-of-range redirect target
        rst = 1'b1; #2; rst = 1'b0;
        tick();
        chk("rst2_fault", 32'(fault), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        redirect = 1'b1; redirect_pc = MEM_BYTES;
        tick();
        redirect = 1'b0;
        chk("oor_read_address", read_address, 32'd256);
        chk("oor_no_fault_yet", 32'(fault), 32'h0);
        chk("oor_fetch_count", fetch_count, 32'd2);
        tick();
        chk("oor_fault", 32'(fault), 32'h1);
        chk("oor_if_valid", 32'(if_valid), 32'h0);

        // Asynchronous reset mid-cycle with if_valid high
        rst = 1'b1; #2; rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("async_pre_valid", 32'(if_valid), 32'h1);
        chk("async_pre_addr", read_address, 32'd8);
        #2 rst = 1'b1;
        #1;
        chk("async_if_valid", 32'(if_valid), 32'h0);
        chk("async_read_address", read_address, RESET_PC);
        chk("async_fetch_count", fetch_count, 32'd0);
        #3 rst = 1'b0;
        tick();
        tick();
        chk("async_idle_valid", 32'(if_valid), 32'h0);
        chk("async_idle_addr", read_address, RESET_PC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
